// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state encoding and frame constants for the program loader
package boot_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} state_t;
  localparam logic [7:0] BOOT_MAGIC = 8'hA5;
  localparam int LEN_BYTES = 4;
endpackage

// File: rtl/boot_word_packer.sv
// boot_word_packer: little-endian byte-lane buffer with strobe accumulation and clear-on-issue
module boot_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [2:0]  lane,
  input  logic [7:0]  din,
  input  logic        clr,
  output logic [63:0] word,
  output logic [7:0]  strb
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      word <= '0;
      strb <= '0;
    end else if (clr) begin
      word <= '0;
      strb <= '0;
    end else if (wr) begin
      word[{lane, 3'b000} +: 8] <= din;
      strb[lane] <= 1'b1;
    end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: framed byte stream to 64-bit memory writes; holds the core in reset until the checksum verifies
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] LOAD_BASE = 64'h8000_0000,
  parameter logic [31:0]     MAX_BYTES = 32'h0001_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [63:0]     mem_req_wdata,
  output logic [7:0]      mem_req_wstrb,
  output logic            core_resetn,
  output logic            done,
  output logic            err
);
  state_t      state;
  logic [31:0] cnt, len;
  logic [7:0]  csum;
  logic        issue, last_w, chk, chk_ok;
  logic [63:0] word;
  logic [7:0]  strb;
  logic        acc, last, full;
  logic [31:0] n_next;
  assign acc    = rx_valid & rx_ready;
  assign n_next = {rx_data, len[31:8]};
  assign last   = cnt == len - 32'd1;
  assign full   = &cnt[2:0];
  boot_word_packer u_packer (
    .clk  (clk),
    .reset(reset),
    .wr   (acc && state == DATA),
    .lane (cnt[2:0]),
    .din  (rx_data),
    .clr  (issue),
    .word (word),
    .strb (strb)
  );
  // issue stages one cycle after the byte so the packer holds the completed word
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      len           <= '0;
      csum          <= '0;
      issue         <= 1'b0;
      last_w        <= 1'b0;
      chk           <= 1'b0;
      chk_ok        <= 1'b0;
      rx_ready      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      core_resetn   <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (acc && rx_data == BOOT_MAGIC) begin
            state <= LEN;
            cnt   <= '0;
            csum  <= '0;
          end
        end
        LEN: if (acc) begin
          len <= n_next;
          cnt <= cnt + 32'd1;
          if (cnt == 32'(LEN_BYTES - 1)) begin
            cnt <= '0;
            if (n_next > MAX_BYTES) begin
              state <= ERROR;
              err   <= 1'b1;
            end else state <= (n_next == '0) ? CSUM : DATA;
          end
        end
        DATA: begin
          if (mem_req_valid) begin
            if (mem_req_ready) begin
              mem_req_valid <= 1'b0;
              rx_ready      <= 1'b1;
              if (last_w) state <= CSUM;
            end
          end else if (issue) begin
            issue         <= 1'b0;
            mem_req_valid <= 1'b1;
            mem_req_wdata <= word;
            mem_req_wstrb <= strb;
          end else if (acc) begin
            csum <= csum ^ rx_data;
            cnt  <= cnt + 32'd1;
            if (full || last) begin
              issue        <= 1'b1;
              rx_ready     <= 1'b0;
              last_w       <= last;
              mem_req_addr <= LOAD_BASE + XLEN'({cnt[31:3], 3'b000});
            end
          end
        end
        CSUM: begin
          if (chk) begin
            chk         <= 1'b0;
            state       <= chk_ok ? DONE : ERROR;
            done        <= chk_ok;
            core_resetn <= chk_ok;
            err         <= !chk_ok;
            rx_ready    <= !chk_ok;
          end else if (acc) begin
            chk      <= 1'b1;
            chk_ok   <= rx_data == csum;
            rx_ready <= 1'b0;
          end
        end
        DONE: rx_ready <= 1'b0;
        ERROR: begin
          rx_ready <= 1'b1;
          if (acc && rx_data == BOOT_MAGIC) begin
            err   <= 1'b0;
            csum  <= '0;
            cnt   <= '0;
            state <= LEN;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
